// File: rtl/anton_neopixel_multistream.sv
// anton_neopixel_multistream
//   Drives CHANNELS NeoPixel strips in lockstep. One pixel word carries data for
//   all lanes. Words are pulled over a ready/valid handshake, and a one-entry
//   holding register prefetches the next word. Each data bit lasts CLK_PER_BIT
//   clocks and stays high for T1H clocks ('1') or T0H clocks ('0'). Bits go out
//   MSB first. After the last bit the outputs stay low for LATCH_CYCLES clocks,
//   and then done pulses for one cycle.
//
// Ports
//   clk         single clock
//   syncReset   synchronous reset, active-high
//   start       begin a frame (IDLE only); pixelCount/mode32 are captured with it
//   pixelCount  pixels per channel
//   mode32      1 = 32-bit GRBW word, 0 = 24-bit GRB word (uses [23:0] of a lane)
//   pixelData   lane c at [c*32 +: 32]
//   pixelValid  pixelData is valid
//   pixelReady  a word is accepted on pixelValid & pixelReady
//   pixelIndex  index of the next word requested
//   busy        high in every state except IDLE
//   done        one-cycle pulse on the last LATCH cycle
//   underrun    sticky stall flag, cleared by start
//   neoData     serial strip outputs
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start
// S_FETCH | first word of the frame requested
// S_SEND  | bits being serialised; the next word may be prefetched
// S_STALL | word boundary reached with no data; outputs held low
// S_LATCH | low reset/latch period before done

module anton_neopixel_multistream #(
  parameter int CHANNELS     = 1,
  parameter int COUNT_BITS   = 10,
  parameter int CLK_PER_BIT  = 25,
  parameter int T0H          = 7,
  parameter int T1H          = 14,
  parameter int LATCH_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    syncReset,
  input  logic                    start,
  input  logic [COUNT_BITS-1:0]   pixelCount,
  input  logic                    mode32,
  input  logic [CHANNELS*32-1:0]  pixelData,
  input  logic                    pixelValid,
  output logic                    pixelReady,
  output logic [COUNT_BITS-1:0]   pixelIndex,
  output logic                    busy,
  output logic                    done,
  output logic                    underrun,
  output logic [CHANNELS-1:0]     neoData
);

  localparam int TW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int LW = (LATCH_CYCLES > 0) ? $clog2(LATCH_CYCLES + 1) : 1;

  localparam logic [TW-1:0]         T_LAST     = TW'(CLK_PER_BIT - 1);
  localparam logic [TW-1:0]         T0H_C      = TW'(T0H);
  localparam logic [TW-1:0]         T1H_C      = TW'(T1H);
  localparam logic [TW-1:0]         TIMER_ONE  = TW'(1);
  localparam logic [LW-1:0]         LATCH_LOAD = LW'(LATCH_CYCLES - 1);
  localparam logic [LW-1:0]         LATCH_ONE  = LW'(1);
  localparam logic [COUNT_BITS-1:0] IDX_ONE    = COUNT_BITS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_STALL,
    S_LATCH
  } state_t;

  state_t                      state_q, state_d;
  logic [COUNT_BITS-1:0]       count_q, count_d;
  logic [COUNT_BITS-1:0]       index_q, index_d;
  logic                        mode32_q, mode32_d;
  logic [CHANNELS-1:0][31:0]   pix_q, pix_d;
  logic [CHANNELS-1:0][31:0]   hold_q, hold_d;
  logic                        hold_full_q, hold_full_d;
  logic [TW-1:0]               timer_q, timer_d;
  logic [4:0]                  bit_idx_q, bit_idx_d;
  logic [LW-1:0]               latch_q, latch_d;
  logic                        underrun_q, underrun_d;

  logic       handshake;
  logic       more_pixels;
  logic       bit_last;
  logic [4:0] top_bit;

  assign more_pixels = (index_q < count_q);
  assign bit_last    = (timer_q == T_LAST);
  assign top_bit     = mode32_q ? 5'd31 : 5'd23;

  always_comb begin
    pixelReady = 1'b0;
    case (state_q)
      S_FETCH, S_STALL: pixelReady = 1'b1;
      S_SEND:           pixelReady = !hold_full_q && more_pixels;
      default:          pixelReady = 1'b0;
    endcase
    handshake = pixelValid && pixelReady;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    index_d     = index_q;
    mode32_d    = mode32_q;
    pix_d       = pix_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    latch_d     = latch_q;
    underrun_d  = underrun_q;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d     = pixelCount;
          mode32_d    = mode32;
          index_d     = '0;
          underrun_d  = 1'b0;
          hold_full_d = 1'b0;
          if (pixelCount == '0) begin
            state_d = S_LATCH;
            latch_d = LATCH_LOAD;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH, S_STALL: begin
        if (handshake) begin
          pix_d     = pixelData;
          index_d   = index_q + IDX_ONE;
          bit_idx_d = top_bit;
          timer_d   = '0;
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        if (!bit_last) begin
          timer_d = timer_q + TIMER_ONE;
          if (handshake) begin
            hold_d      = pixelData;
            hold_full_d = 1'b1;
            index_d     = index_q + IDX_ONE;
          end
        end else begin
          timer_d = '0;
          if (bit_idx_q != 5'd0) begin
            bit_idx_d = bit_idx_q - 5'd1;
            if (handshake) begin
              hold_d      = pixelData;
              hold_full_d = 1'b1;
              index_d     = index_q + IDX_ONE;
            end
          end else if (hold_full_q) begin
            pix_d       = hold_q;
            hold_full_d = 1'b0;
            bit_idx_d   = top_bit;
          end else if (handshake) begin
            // Word arrives exactly at the boundary: bypass the holding register.
            pix_d     = pixelData;
            index_d   = index_q + IDX_ONE;
            bit_idx_d = top_bit;
          end else if (more_pixels) begin
            state_d    = S_STALL;
            underrun_d = 1'b1;
          end else begin
            state_d = S_LATCH;
            latch_d = LATCH_LOAD;
          end
        end
      end

      S_LATCH: begin
        if (latch_q == '0) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          latch_d = latch_q - LATCH_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    neoData = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      neoData[c] = (state_q == S_SEND) &&
                   (timer_q < (pix_q[c][bit_idx_q] ? T1H_C : T0H_C));
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign underrun   = underrun_q;
  assign pixelIndex = index_q;

  always_ff @(posedge clk) begin
    if (syncReset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      index_q     <= '0;
      mode32_q    <= 1'b0;
      pix_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      latch_q     <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      index_q     <= index_d;
      mode32_q    <= mode32_d;
      pix_q       <= pix_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      latch_q     <= latch_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_anton_neopixel_multistream.sv
// Testbench for anton_neopixel_multistream (CHANNELS=2, default timing).
// A timing model computes when each word is accepted and when each pixel starts.
// From that it derives the expected pulse starts and widths on every lane, the
// done cycle, the busy length and the underrun flag.

module tb_anton_neopixel_multistream;

  localparam int CH     = 2;
  localparam int CB     = 10;
  localparam int CPB    = 25;
  localparam int T0     = 7;
  localparam int T1     = 14;
  localparam int LAT    = 1000;
  localparam int MAXP   = 4;
  localparam int BUDGET = 20000;

  logic              clk = 1'b0;
  logic              syncReset;
  logic              start;
  logic [CB-1:0]     pixelCount;
  logic              mode32;
  logic [CH*32-1:0]  pixelData;
  logic              pixelValid;
  logic              pixelReady;
  logic [CB-1:0]     pixelIndex;
  logic              busy;
  logic              done;
  logic              underrun;
  logic [CH-1:0]     neoData;

  anton_neopixel_multistream #(
    .CHANNELS(CH), .COUNT_BITS(CB), .CLK_PER_BIT(CPB),
    .T0H(T0), .T1H(T1), .LATCH_CYCLES(LAT)
  ) dut (
    .clk(clk), .syncReset(syncReset), .start(start), .pixelCount(pixelCount),
    .mode32(mode32), .pixelData(pixelData), .pixelValid(pixelValid),
    .pixelReady(pixelReady), .pixelIndex(pixelIndex), .busy(busy), .done(done),
    .underrun(underrun), .neoData(neoData)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] words  [MAXP][CH];
  int          delays [MAXP];
  int          exp_start [CH][$];
  int          exp_w     [CH][$];
  int          obs_start [CH][$];
  int          obs_w     [CH][$];
  int          model_s   [MAXP];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Computes pixel start cycles (cycle 0 = first cycle after the start edge).
  task automatic model_frame(input int cnt, input bit m32,
                             output int done_exp, output bit exp_ur);
    int bits, fb, v, b;
    int h [MAXP];
    bits   = m32 ? 32 : 24;
    fb     = bits * CPB;
    exp_ur = 1'b0;
    for (int c = 0; c < CH; c++) begin
      exp_start[c].delete(); exp_w[c].delete();
    end
    if (cnt == 0) begin
      done_exp = LAT - 1;
    end else begin
      h[0]       = delays[0];
      model_s[0] = h[0] + 1;
      for (int k = 1; k < cnt; k++) begin
        v    = h[k-1] + 1 + delays[k];
        h[k] = (v > model_s[k-1]) ? v : model_s[k-1];
        b    = model_s[k-1] + fb - 1;
        if (h[k] <= b) model_s[k] = b + 1;
        else begin
          model_s[k] = h[k] + 1;
          exp_ur     = 1'b1;
        end
      end
      done_exp = model_s[cnt-1] + fb - 1 + LAT;
      for (int k = 0; k < cnt; k++)
        for (int j = 0; j < bits; j++)
          for (int c = 0; c < CH; c++) begin
            exp_start[c].push_back(model_s[k] + j * CPB);
            exp_w[c].push_back(words[k][c][bits-1-j] ? T1 : T0);
          end
    end
  endtask

  task automatic run_frame(input string tag, input int cnt, input bit m32,
                           input int abort_at, input bit poke);
    int cyc, busy_cnt, done_cyc, p, dly, mism, first_bad, done_exp;
    bit exp_ur, aborted;
    logic [CH-1:0] prev;
    int rise [CH];
    model_frame(cnt, m32, done_exp, exp_ur);
    for (int c = 0; c < CH; c++) begin
      obs_start[c].delete(); obs_w[c].delete(); rise[c] = 0;
    end
    @(negedge clk);
    start = 1'b1; pixelCount = CB'(cnt); mode32 = m32; pixelValid = 1'b0;
    @(negedge clk);
    start = 1'b0; pixelCount = CB'($urandom); mode32 = 1'($urandom);
    cyc = 0; busy_cnt = 0; done_cyc = -1; p = 0; dly = delays[0];
    prev = '0; aborted = 1'b0;
    while (cyc < BUDGET) begin
      for (int c = 0; c < CH; c++) begin
        if (neoData[c] && !prev[c]) rise[c] = cyc;
        if (!neoData[c] && prev[c]) begin
          obs_start[c].push_back(rise[c]);
          obs_w[c].push_back(cyc - rise[c]);
        end
      end
      prev = neoData;
      if (busy) busy_cnt++;
      if (cyc == abort_at) begin aborted = 1'b1; break; end
      if (done) begin done_cyc = cyc; break; end
      pixelData = {$urandom, $urandom};
      pixelValid = 1'b0;
      if (p < cnt) begin
        if (dly > 0) dly--;
        else begin
          pixelValid = 1'b1;
          pixelData  = {words[p][1], words[p][0]};
          if (pixelReady) begin
            p++;
            dly = (p < MAXP) ? delays[p] : 0;
          end
        end
      end
      start = 1'b0;
      if (poke && cyc >= 10 && cyc < 13) begin
        start = 1'b1; pixelCount = CB'(3); pixelValid = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; pixelValid = 1'b0;
    if (aborted) return;
    check({tag, " done cycle"}, 64'(done_cyc), 64'(done_exp));
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(done_exp + 1));
    check({tag, " underrun"}, 64'(underrun), 64'(exp_ur));
    check({tag, " pixelIndex end"}, 64'(pixelIndex), 64'(cnt));
    for (int c = 0; c < CH; c++) begin
      check($sformatf("%s lane%0d pulse count", tag, c),
            64'(obs_w[c].size()), 64'(exp_w[c].size()));
      mism = 0; first_bad = -1;
      for (int i = 0; i < obs_w[c].size() && i < exp_w[c].size(); i++)
        if (obs_start[c][i] != exp_start[c][i] || obs_w[c][i] != exp_w[c][i]) begin
          mism++;
          if (first_bad < 0) first_bad = i;
        end
      check($sformatf("%s lane%0d pulse mismatches (first %0d)", tag, c, first_bad),
            64'(mism), 64'd0);
    end
    @(negedge clk);
    check({tag, " busy after done"}, 64'(busy), 64'd0);
    check({tag, " done single pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    syncReset = 1'b1; start = 1'b0; pixelCount = '0; mode32 = 1'b0;
    pixelData = '0; pixelValid = 1'b0;
    for (int k = 0; k < MAXP; k++) begin
      delays[k] = 0;
      for (int c = 0; c < CH; c++) words[k][c] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset neoData", 64'(neoData), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset underrun", 64'(underrun), 64'd0);
    check("reset pixelIndex", 64'(pixelIndex), 64'd0);
    check("reset pixelReady", 64'(pixelReady), 64'd0);
    syncReset = 1'b0;
    @(negedge clk);

    // 1) 24-bit single pixel 0x800001 on lane 0
    words[0][0] = 32'h0080_0001; words[0][1] = $urandom;
    run_frame("t1", 1, 1'b0, -1, 1'b0);
    check("t1 first bit width", 64'(obs_w[0].size() > 0 ? obs_w[0][0] : -1), 64'(T1));
    check("t1 second bit width", 64'(obs_w[0].size() > 1 ? obs_w[0][1] : -1), 64'(T0));
    check("t1 last bit width", 64'(obs_w[0].size() == 24 ? obs_w[0][23] : -1), 64'(T1));

    // 2) 32-bit, two pixels, lane0 all ones, lane1 all zeros, valid always
    for (int k = 0; k < 2; k++) begin
      words[k][0] = 32'hFFFF_FFFF; words[k][1] = 32'h0; delays[k] = 0;
    end
    run_frame("t2", 2, 1'b1, -1, 1'b0);

    // 3) stall before pixel 2
    for (int k = 0; k < 3; k++) begin
      words[k][0] = $urandom; words[k][1] = $urandom;
    end
    delays[0] = 0; delays[1] = 640; delays[2] = 0;
    run_frame("t3", 3, 1'b0, -1, 1'b0);

    // 4) zero-length frame, start/valid poked while busy
    run_frame("t4", 0, 1'b0, -1, 1'b1);

    // 5) syncReset mid-bit of pixel 2 (pixel 2 starts at cycle 642 after the stall)
    run_frame("t5", 3, 1'b0, 642 + 5 * CPB + 3, 1'b0);
    check("t5 busy before reset", 64'(busy), 64'd1);
    check("t5 underrun before reset", 64'(underrun), 64'd1);
    check("t5 index before reset", 64'(pixelIndex), 64'd3);
    syncReset = 1'b1;
    @(negedge clk);
    check("t5 neoData after reset", 64'(neoData), 64'd0);
    check("t5 busy after reset", 64'(busy), 64'd0);
    check("t5 pixelIndex after reset", 64'(pixelIndex), 64'd0);
    check("t5 underrun after reset", 64'(underrun), 64'd0);
    check("t5 pixelReady after reset", 64'(pixelReady), 64'd0);
    syncReset = 1'b0;
    delays[0] = 0; delays[1] = 0;
    words[0][0] = $urandom; words[0][1] = $urandom;
    words[1][0] = $urandom; words[1][1] = $urandom;
    run_frame("t5 fresh", 2, 1'b1, -1, 1'b0);

    // 6) word offered exactly on the pixel boundary, and one cycle late
    delays[0] = 0; delays[1] = 24 * CPB - 1;
    run_frame("t6 24b", 2, 1'b0, -1, 1'b0);
    delays[1] = 32 * CPB - 1;
    run_frame("t6 32b", 2, 1'b1, -1, 1'b0);
    delays[1] = 24 * CPB;
    run_frame("t6 late", 2, 1'b0, -1, 1'b0);

    // Randomised frames
    for (int f = 0; f < 6; f++) begin
      int cnt, sel;
      bit m32;
      cnt = $urandom_range(1, MAXP);
      m32 = 1'($urandom);
      for (int k = 0; k < MAXP; k++) begin
        words[k][0] = $urandom; words[k][1] = $urandom;
        sel = $urandom_range(0, 3);
        case (sel)
          0:       delays[k] = 0;
          1:       delays[k] = $urandom_range(0, 40);
          2:       delays[k] = (m32 ? 32 : 24) * CPB - 1;
          default: delays[k] = (m32 ? 32 : 24) * CPB + $urandom_range(0, 60);
        endcase
      end
      run_frame($sformatf("rand%0d", f), cnt, m32, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
